// File: rtl/parity_frame_pkg.sv
// Shared definitions for the parity-framed serial link (receive and transmit sides).
package parity_frame_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned PAR_EVEN = 0;
  localparam int unsigned PAR_ODD  = 1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_BREAK  = 3'd4
  } state_t;

endpackage

// File: rtl/parity_tree.sv
// Parameterized XOR reduction; returns 1 when an odd number of input bits are set.
module parity_tree #(
  parameter int unsigned WIDTH = 9
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_parity
);

  assign o_parity = ^i_data;

endmodule

// File: rtl/parity_frame_rx.sv
// Frame receiver: start, DATA_W data bits LSB-first, parity, stop; valid/ready output and saturating error count.
module parity_frame_rx
  import parity_frame_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY_ODD = PAR_EVEN,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);

  localparam int unsigned     IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W:0]   CNT_MAX  = {1'b0, {CNT_W{1'b1}}};

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              r_par, w_par_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_perr, w_perr_nxt;
  logic              r_ferr, w_ferr_nxt;
  logic              r_ovr, w_ovr_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_busy;
  logic              w_xor;
  logic              w_par_ok;
  logic [1:0]        w_inc;
  logic [CNT_W:0]    w_cnt_sum;

  parity_tree #(.WIDTH(DATA_W + 1)) u_parity_tree (
    .i_data   ({r_shift, r_par}),
    .o_parity (w_xor)
  );

  assign w_par_ok = (w_xor == 1'(PARITY_ODD));

  // Next-state and datapath updates; nothing advances without a bit strobe except the output handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid & ~data_ready;
    w_perr_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_ovr_nxt   = 1'b0;
    if (bit_en) begin
      case (r_state)
        ST_IDLE: begin
          if (!rx_bit) begin
            w_state_nxt = ST_DATA;
            w_idx_nxt   = '0;
            w_shift_nxt = '0;
          end
        end
        ST_DATA: begin
          w_shift_nxt[r_idx] = rx_bit;
          if (r_idx == IDX_LAST) begin
            w_state_nxt = ST_PARITY;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
        ST_PARITY: begin
          w_par_nxt   = rx_bit;
          w_state_nxt = ST_STOP;
        end
        ST_STOP: begin
          if (rx_bit) begin
            w_state_nxt = ST_IDLE;
            if (!w_par_ok) begin
              w_perr_nxt = 1'b1;
            end else if (!r_valid || data_ready) begin
              w_data_nxt  = r_shift;
              w_valid_nxt = 1'b1;
            end else begin
              w_ovr_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = ST_BREAK;
            w_ferr_nxt  = 1'b1;
            w_perr_nxt  = ~w_par_ok;
          end
        end
        ST_BREAK: begin
          if (rx_bit) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Saturating add of this cycle's error events (0..2).
  assign w_inc     = {1'b0, w_perr_nxt} + {1'b0, w_ferr_nxt} + {1'b0, w_ovr_nxt};
  assign w_cnt_sum = (CNT_W + 1)'(r_cnt) + (CNT_W + 1)'(w_inc);
  assign w_cnt_nxt = (w_cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_perr  <= w_perr_nxt;
      r_ferr  <= w_ferr_nxt;
      r_ovr   <= w_ovr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;
  assign err_cnt    = r_cnt;
  assign busy       = r_busy;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Randomized bench: even, odd and 2-bit-counter receivers on one shared line, checked against a frame-level model.
module tb_parity_frame_rx;

  localparam int N   = 3;
  localparam int MEM = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, bit_en, rx_bit, data_ready;
  logic [7:0] dout [N];
  logic       valid [N];
  logic       perr [N];
  logic       ferr [N];
  logic       ovr [N];
  logic       busy [N];
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(0), .CNT_W(8)) u_even (
    .clk(clk), .rst(rst), .bit_en(bit_en), .rx_bit(rx_bit),
    .data_out(dout[0]), .data_valid(valid[0]), .data_ready(data_ready),
    .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]),
    .err_cnt(cnt0), .busy(busy[0]));

  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1), .CNT_W(8)) u_odd (
    .clk(clk), .rst(rst), .bit_en(bit_en), .rx_bit(rx_bit),
    .data_out(dout[1]), .data_valid(valid[1]), .data_ready(data_ready),
    .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]),
    .err_cnt(cnt1), .busy(busy[1]));

  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .bit_en(bit_en), .rx_bit(rx_bit),
    .data_out(dout[2]), .data_valid(valid[2]), .data_ready(data_ready),
    .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]),
    .err_cnt(cnt2), .busy(busy[2]));

  int         mode [N] = '{0, 1, 0};
  int         cmax [N] = '{255, 255, 3};
  bit         exp_full [N];
  logic [7:0] exp_held [N];
  int         exp_perr [N], exp_ferr [N], exp_ovr [N], exp_err [N];
  logic [7:0] exp_mem [N][MEM];
  int         exp_n [N];
  int         mon_perr [N], mon_ferr [N], mon_ovr [N];
  logic [7:0] rx_mem [N][MEM];
  int         rx_n [N];
  int         chk_pos [N];
  int         n_vec, n_bad;

  // Observe handshakes and pulse cycles on the edge opposite to the DUT's.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (valid[k] && data_ready && rx_n[k] < MEM) begin
        rx_mem[k][rx_n[k]] <= dout[k];
        rx_n[k]            <= rx_n[k] + 1;
      end
      mon_perr[k] <= mon_perr[k] + int'(perr[k]);
      mon_ferr[k] <= mon_ferr[k] + int'(ferr[k]);
      mon_ovr[k]  <= mon_ovr[k] + int'(ovr[k]);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cnt_of(input int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int k, input logic [7:0] w);
    if (exp_n[k] < MEM) begin
      exp_mem[k][exp_n[k]] = w;
      exp_n[k]++;
    end
  endtask

  task automatic send_bit(input logic b, input int gapmax);
    rx_bit = b;
    bit_en = 1'b1;
    step();
    bit_en = 1'b0;
    rx_bit = 1'($urandom);
    repeat (int'($urandom_range(gapmax, 0))) step();
  endtask

  // One frame; flip inverts the even-parity bit, stop=0 holds the line low low_n extra strobes.
  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop, input int low_n,
                            input int gapmax, input logic rdy_stop, input logic rdy_idle);
    logic par;
    bit   ok, dlv [N];
    par = (^d) ^ flip;
    send_bit(1'b0, gapmax);
    for (int i = 0; i < 8; i++) send_bit(d[i], gapmax);
    send_bit(par, gapmax);
    for (int k = 0; k < N; k++) check($sformatf("valid_pre[%0d]", k), int'(valid[k]), int'(exp_full[k]));
    rx_bit     = stop;
    data_ready = rdy_stop;
    bit_en     = 1'b1;
    step();
    bit_en     = 1'b0;
    data_ready = rdy_idle;
    for (int k = 0; k < N; k++) begin
      ok     = ((^{d, par}) == 1'(mode[k]));
      dlv[k] = 1'b0;
      if (stop) begin
        if (!ok) begin
          exp_perr[k]++; exp_err[k]++;
        end else if (!exp_full[k] || rdy_stop) begin
          if (exp_full[k]) push_exp(k, exp_held[k]);
          exp_held[k] = d;
          exp_full[k] = 1'b1;
          dlv[k]      = 1'b1;
        end else begin
          exp_ovr[k]++; exp_err[k]++;
        end
      end else begin
        exp_ferr[k]++; exp_err[k]++;
        if (!ok) begin
          exp_perr[k]++; exp_err[k]++;
        end
      end
      if (dlv[k]) begin
        check($sformatf("valid_lat[%0d]", k), int'(valid[k]), 1);
        check($sformatf("dout_lat[%0d]", k), int'(dout[k]), int'(d));
      end
    end
    if (!stop) begin
      repeat (low_n) send_bit(1'b0, gapmax);
      for (int k = 0; k < N; k++) check($sformatf("busy_break[%0d]", k), int'(busy[k]), 1);
      send_bit(1'b1, gapmax);
    end else begin
      repeat (int'($urandom_range(gapmax, 0))) step();
    end
  endtask

  task automatic settle();
    step();
    step();
    if (data_ready) begin
      for (int k = 0; k < N; k++) begin
        if (exp_full[k]) push_exp(k, exp_held[k]);
        exp_full[k] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    int ec;
    for (int k = 0; k < N; k++) begin
      check($sformatf("rx_count[%0d]", k), rx_n[k], exp_n[k]);
      while (chk_pos[k] < rx_n[k] && chk_pos[k] < exp_n[k]) begin
        check($sformatf("rx_word[%0d]", k), int'(rx_mem[k][chk_pos[k]]), int'(exp_mem[k][chk_pos[k]]));
        chk_pos[k]++;
      end
      chk_pos[k] = (rx_n[k] > exp_n[k]) ? rx_n[k] : exp_n[k];
      ec = (exp_err[k] > cmax[k]) ? cmax[k] : exp_err[k];
      check($sformatf("parity_err_n[%0d]", k), mon_perr[k], exp_perr[k]);
      check($sformatf("frame_err_n[%0d]", k), mon_ferr[k], exp_ferr[k]);
      check($sformatf("overrun_n[%0d]", k), mon_ovr[k], exp_ovr[k]);
      check($sformatf("err_cnt[%0d]", k), cnt_of(k), ec);
      check($sformatf("valid[%0d]", k), int'(valid[k]), int'(exp_full[k]));
      if (exp_full[k]) check($sformatf("dout_held[%0d]", k), int'(dout[k]), int'(exp_held[k]));
      check($sformatf("busy_idle[%0d]", k), int'(busy[k]), 0);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_dout[%0d]", tag, k), int'(dout[k]), 0);
      check($sformatf("%s_valid[%0d]", tag, k), int'(valid[k]), 0);
      check($sformatf("%s_pulses[%0d]", tag, k), int'({perr[k], ferr[k], ovr[k]}), 0);
      check($sformatf("%s_cnt[%0d]", tag, k), cnt_of(k), 0);
      check($sformatf("%s_busy[%0d]", tag, k), int'(busy[k]), 0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    for (int k = 0; k < N; k++) begin
      exp_full[k] = 1'b0; exp_held[k] = '0;
      exp_perr[k] = 0; exp_ferr[k] = 0; exp_ovr[k] = 0; exp_err[k] = 0;
      exp_n[k] = 0; chk_pos[k] = 0;
      mon_perr[k] = 0; mon_ferr[k] = 0; mon_ovr[k] = 0; rx_n[k] = 0;
    end
    rst = 1'b1; bit_en = 1'b0; rx_bit = 1'b1; data_ready = 1'b1;
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;
    step();

    // Clean frame, then flipped parity (odd build accepts it), then a held-low break.
    send_frame(8'hA5, 1'b0, 1'b1, 0, 0, 1'b1, 1'b1); settle(); check_all();
    send_frame(8'hA5, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1); settle(); check_all();
    send_frame(8'h5C, 1'b0, 1'b0, 4, 1, 1'b1, 1'b1); settle(); check_all();

    // Stalled consumer: overrun on the second word, then back-to-back reload.
    data_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0); settle(); check_all();
    send_frame(8'h22, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0); settle(); check_all();
    send_frame(8'h22, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0); settle(); check_all();
    data_ready = 1'b1;
    settle(); check_all();

    // Reset during data bit 4.
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    rx_bit = 1'b0; bit_en = 1'b1; rst = 1'b1;
    step();
    bit_en = 1'b0; rst = 1'b0;
    check_zero("midrst");
    for (int k = 0; k < N; k++) begin
      exp_full[k] = 1'b0;
      exp_err[k]  = 0;
    end
    send_frame(8'h3C, 1'b0, 1'b1, 0, 2, 1'b1, 1'b1); settle(); check_all();

    // Saturation of the 2-bit counter.
    repeat (5) begin
      send_frame(8'($urandom), 1'b1, 1'b1, 0, 3, 1'b1, 1'b1); settle(); check_all();
    end

    // Random frames with strobe gaps of 0..7 clocks.
    repeat (40) begin
      send_frame(8'($urandom), ($urandom_range(3, 0) == 0), ($urandom_range(5, 0) != 0),
                 int'($urandom_range(3, 0)), 7, 1'b1, 1'b1);
      settle();
      check_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
